// File: rtl/asrm_interrupt_scheduler.sv
// Purpose : prioritising interrupt scheduler; edge capture, enable mask, nested in-service tracking, single offer to CPU.
// Latency : ext_int edge -> pending after 1 edge, int_req after 2 edges; ack -> next offer no earlier than 2 edges later.
// Backpr. : an offer waits in IDLE while cpu_ready is low; once raised, int_req holds (id frozen) until int_ack.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   ext_int[3:0]       external interrupt lines, bit 0 highest priority
//   mask_we, mask_in   enable-mask write strobe and value (low 4 bits used)
//   cpu_ready          CPU at an instruction boundary with memory not stalling
//   int_ack, int_done  CPU accepts the offer / CPU executed retint (one-cycle pulses)
//   int_req, int_id    registered offer and index of the offered interrupt
//   pending            latched rising edges not yet accepted
//   in_service         bitmap of nested interrupts currently being serviced
//   mask               current enable mask
module asrm_interrupt_scheduler #(
   parameter int wordsize = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          ext_int,
   input  logic                mask_we,
   input  logic [wordsize-1:0] mask_in,
   input  logic                cpu_ready,
   input  logic                int_ack,
   input  logic                int_done,
   output logic                int_req,
   output logic [1:0]          int_id,
   output logic [3:0]          pending,
   output logic [3:0]          in_service,
   output logic [3:0]          mask
);

   typedef enum logic [1:0] {IDLE, REQ, ACKED} state_t;

   state_t     state;
   logic [3:0] ext_d;
   // Lines that were high while reset was asserted; each bit stays set until
   // its line drops, so a level held across reset release never looks like an edge.
   logic [3:0] hold;

   logic [3:0] rise;
   logic [3:0] allowed;
   logic [3:0] eligible;
   logic [3:0] done_clr;
   logic [3:0] ack_set;
   logic [1:0] winner;
   logic       have_winner;
   logic       ack_ok;

   // Upper mask_in bits carry no meaning for this block.
   logic unused_mask_bits;
   assign unused_mask_bits = ^mask_in[wordsize-1:4];

   always_comb begin
      rise = ext_int & ~ext_d & ~hold;

      // Source i may pre-empt only if nothing at index <= i is in service.
      allowed = {~|in_service[3:0], ~|in_service[2:0], ~|in_service[1:0], ~in_service[0]};
      eligible = pending & mask & allowed;

      have_winner = |eligible;
      if (eligible[0])      winner = 2'd0;
      else if (eligible[1]) winner = 2'd1;
      else if (eligible[2]) winner = 2'd2;
      else                  winner = 2'd3;

      // Isolate the lowest set bit: the innermost (highest-priority) nesting level.
      done_clr = int_done ? (in_service & (~in_service + 4'd1)) : 4'd0;

      ack_ok  = (state == REQ) && int_ack;
      ack_set = ack_ok ? (4'd1 << int_id) : 4'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         int_req    <= 1'b0;
         int_id     <= 2'd0;
         pending    <= 4'd0;
         in_service <= 4'd0;
         mask       <= 4'd0;
         ext_d      <= 4'd0;
         hold       <= ext_int;
      end else begin
         ext_d <= ext_int;
         hold  <= hold & ext_int;

         // A fresh edge on the acked line wins over the ack clear.
         pending <= (pending & ~ack_set) | rise;

         // Done retires the old innermost level before the acked bit is added.
         in_service <= (in_service & ~done_clr) | ack_set;

         if (mask_we) mask <= mask_in[3:0];

         case (state)
            IDLE: begin
               if (have_winner && cpu_ready) begin
                  state   <= REQ;
                  int_req <= 1'b1;
                  int_id  <= winner;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state   <= ACKED;
                  int_req <= 1'b0;
               end
            end
            ACKED: begin
               // One quiet cycle lets the CPU fetch the first handler instruction.
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               int_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_asrm_interrupt_scheduler.sv
module tb_asrm_interrupt_scheduler;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   ext_int;
   logic         mask_we;
   logic [W-1:0] mask_in;
   logic         cpu_ready;
   logic         int_ack;
   logic         int_done;
   logic         int_req;
   logic [1:0]   int_id;
   logic [3:0]   pending;
   logic [3:0]   in_service;
   logic [3:0]   mask;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   asrm_interrupt_scheduler #(.wordsize(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .ext_int    (ext_int),
      .mask_we    (mask_we),
      .mask_in    (mask_in),
      .cpu_ready  (cpu_ready),
      .int_ack    (int_ack),
      .int_done   (int_done),
      .int_req    (int_req),
      .int_id     (int_id),
      .pending    (pending),
      .in_service (in_service),
      .mask       (mask)
   );

   // ---------------- reference model ----------------
   // Phases: 0 = nothing offered, 1 = offer outstanding, 2 = just accepted.
   logic [3:0] m_pend, m_is, m_mask, m_prev;
   logic       m_req;
   logic [1:0] m_id;
   int         m_ph;

   task automatic model_step();
      int top;
      int win;
      logic [3:0] new_is, new_pend;
      if (reset) begin
         m_pend = 0; m_is = 0; m_mask = 0; m_req = 0; m_id = 0; m_ph = 0;
      end else begin
         top = 4;
         for (int i = 3; i >= 0; i--) if (m_is[i]) top = i;
         win = 4;
         for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i] && i < top) win = i;
         new_is   = m_is;
         new_pend = m_pend;
         if (int_done && top < 4) new_is[top] = 1'b0;
         if (m_ph == 1 && int_ack) begin
            new_is[m_id]   = 1'b1;
            new_pend[m_id] = 1'b0;
         end
         for (int i = 0; i < 4; i++) if (ext_int[i] && !m_prev[i]) new_pend[i] = 1'b1;
         m_is   = new_is;
         m_pend = new_pend;
         if (mask_we) m_mask = mask_in[3:0];
         if (m_ph == 0) begin
            if (win < 4 && cpu_ready) begin
               m_ph = 1; m_req = 1; m_id = 2'(win);
            end
         end else if (m_ph == 1) begin
            if (int_ack) begin m_ph = 2; m_req = 0; end
         end else begin
            m_ph = 0;
         end
      end
      // A line must have been seen low in the previous cycle to count as rising,
      // including across reset.
      m_prev = ext_int;
   endtask

   function automatic logic [14:0] outs();
      return {int_req, int_id, pending, in_service, mask};
   endfunction

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got req=%0b id=%0d pend=%h isvc=%h mask=%h, want req=%0b id=%0d pend=%h isvc=%h mask=%h",
                  name, act[14], act[13:12], act[11:8], act[7:4], act[3:0],
                  exp[14], exp[13:12], exp[11:8], exp[7:4], exp[3:0]);
      end
   endtask

   // Apply inputs, advance one edge, leave time at edge+1 for sampling.
   task automatic cyc(input int rst, input int ext, input int mwe, input int min,
                      input int cr, input int ack, input int done);
      reset     = rst[0];
      ext_int   = ext[3:0];
      mask_we   = mwe[0];
      mask_in   = min[W-1:0];
      cpu_ready = cr[0];
      int_ack   = ack[0];
      int_done  = done[0];
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int rst, ext, mwe, min, cr, ack, done;
      logic [14:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int rst, input int ext, input int mwe, input int min,
                               input int cr, input int ack, input int done,
                               input int req, input int id, input int pend, input int is, input int msk);
      vec_t v;
      v.rst = rst; v.ext = ext; v.mwe = mwe; v.min = min; v.cr = cr; v.ack = ack; v.done = done;
      v.exp = {1'(req), 2'(id), 4'(pend), 4'(is), 4'(msk)};
      return v;
   endfunction

   initial begin
      reset = 1; ext_int = 0; mask_we = 0; mask_in = 0; cpu_ready = 0; int_ack = 0; int_done = 0;
      m_prev = 0; m_pend = 0; m_is = 0; m_mask = 0; m_req = 0; m_id = 0; m_ph = 0;

      //              rst ext mwe min    cr ack dn | req id pend is  mask
      tbl.push_back(mk(1, 0,  0,  0,     0, 0,  0,   0,  0, 0,   0,  0));   // reset state
      tbl.push_back(mk(0, 0,  1,  'hF,   1, 0,  0,   0,  0, 0,   0,  'hF));
      tbl.push_back(mk(0, 4,  0,  0,     1, 0,  0,   0,  0, 4,   0,  'hF)); // edge on 2
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   1,  2, 4,   0,  'hF)); // offer 2
      tbl.push_back(mk(0, 0,  0,  0,     1, 1,  0,   0,  2, 0,   4,  'hF)); // ack 2
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  2, 0,   4,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  2, 0,   4,  'hF));
      tbl.push_back(mk(0, 9,  0,  0,     1, 0,  0,   0,  2, 9,   4,  'hF)); // 0 and 3 rise
      tbl.push_back(mk(0, 9,  0,  0,     1, 0,  0,   1,  0, 9,   4,  'hF)); // offer 0
      tbl.push_back(mk(0, 0,  0,  0,     1, 1,  0,   0,  0, 8,   5,  'hF)); // nested
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  1,   0,  0, 8,   4,  'hF)); // done 0
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  0, 8,   4,  'hF)); // 3 blocked
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  1,   0,  0, 8,   0,  'hF)); // done 2
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   1,  3, 8,   0,  'hF)); // offer 3
      tbl.push_back(mk(0, 0,  0,  0,     1, 1,  0,   0,  3, 0,   8,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  1,   0,  3, 0,   0,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  3, 0,   0,  'hF));
      tbl.push_back(mk(0, 0,  1,  0,     1, 0,  0,   0,  3, 0,   0,  0));   // mask all off
      tbl.push_back(mk(0, 2,  0,  0,     1, 0,  0,   0,  3, 2,   0,  0));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  3, 2,   0,  0));   // masked: no req
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  3, 2,   0,  0));
      tbl.push_back(mk(0, 0,  1,  'h12,  1, 0,  0,   0,  3, 2,   0,  2));   // upper bits ignored
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   1,  1, 2,   0,  2));   // unmasked offer
      tbl.push_back(mk(0, 2,  0,  0,     1, 1,  0,   0,  1, 2,   2,  2));   // edge with ack
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  1, 2,   2,  2));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  1,   0,  1, 2,   0,  2));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   1,  1, 2,   0,  2));
      tbl.push_back(mk(0, 0,  0,  0,     1, 1,  0,   0,  1, 0,   2,  2));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  1,   0,  1, 0,   0,  2));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  1, 0,   0,  2));
      tbl.push_back(mk(0, 0,  0,  0,     1, 1,  1,   0,  1, 0,   0,  2));   // stray ack/done
      tbl.push_back(mk(0, 0,  1,  'hF,   1, 0,  0,   0,  1, 0,   0,  'hF));
      tbl.push_back(mk(0, 8,  0,  0,     0, 0,  0,   0,  1, 8,   0,  'hF)); // stalled
      tbl.push_back(mk(0, 0,  0,  0,     0, 0,  0,   0,  1, 8,   0,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     0, 0,  0,   0,  1, 8,   0,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   1,  3, 8,   0,  'hF));
      tbl.push_back(mk(0, 1,  0,  0,     0, 0,  0,   1,  3, 9,   0,  'hF)); // offer frozen
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   1,  3, 9,   0,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     1, 1,  0,   0,  3, 1,   8,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  3, 1,   8,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   1,  0, 1,   8,  'hF)); // 0 pre-empts 3
      tbl.push_back(mk(1, 4,  0,  0,     1, 0,  0,   0,  0, 0,   0,  0));   // reset in REQ
      tbl.push_back(mk(0, 4,  1,  'hF,   1, 0,  0,   0,  0, 0,   0,  'hF)); // held high
      tbl.push_back(mk(0, 4,  0,  0,     1, 0,  0,   0,  0, 0,   0,  'hF));
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   0,  0, 0,   0,  'hF));
      tbl.push_back(mk(0, 4,  0,  0,     1, 0,  0,   0,  0, 4,   0,  'hF)); // real edge
      tbl.push_back(mk(0, 0,  0,  0,     1, 0,  0,   1,  2, 4,   0,  'hF));

      foreach (tbl[k]) begin
         cyc(tbl[k].rst, tbl[k].ext, tbl[k].mwe, tbl[k].min, tbl[k].cr, tbl[k].ack, tbl[k].done);
         check($sformatf("vec%0d", k), outs(), tbl[k].exp);
      end

      // Hand sequence: ack and done in the same cycle.
      cyc(0, 0, 0, 0, 1, 1, 0);
      check("seq_ack2", outs(), {1'b0, 2'd2, 4'h0, 4'h4, 4'hF});
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 1, 0, 0);
      check("seq_pend0", outs(), {1'b0, 2'd2, 4'h1, 4'h4, 4'hF});
      cyc(0, 0, 0, 0, 1, 0, 0);
      check("seq_offer0", outs(), {1'b1, 2'd0, 4'h1, 4'h4, 4'hF});
      cyc(0, 0, 0, 0, 1, 1, 1);
      check("seq_ack_done", outs(), {1'b0, 2'd0, 4'h0, 4'h1, 4'hF});
      cyc(0, 0, 0, 0, 1, 0, 1);
      check("seq_done_last", outs(), {1'b0, 2'd0, 4'h0, 4'h0, 4'hF});

      // Randomised run against the reference model, starting from reset.
      cyc(1, 0, 0, 0, 0, 0, 0);
      check("rand_reset", outs(), {m_req, m_id, m_pend, m_is, m_mask});
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] nx;
         int rst_r, mwe_r, ack_r, done_r, cr_r;
         nx     = ext_int ^ 4'($urandom & $urandom);
         rst_r  = ($urandom_range(0, 299) == 0) ? 1 : 0;
         mwe_r  = ($urandom_range(0, 15) == 0) ? 1 : 0;
         cr_r   = ($urandom_range(0, 3) != 0) ? 1 : 0;
         ack_r  = int_req ? int'($urandom_range(0, 1)) : (($urandom_range(0, 19) == 0) ? 1 : 0);
         done_r = ($urandom_range(0, 7) == 0) ? 1 : 0;
         cyc(rst_r, int'(nx), mwe_r, int'($urandom_range(0, 65535)), cr_r, ack_r, done_r);
         check($sformatf("rand%0d", c), outs(), {m_req, m_id, m_pend, m_is, m_mask});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
